// File: rtl/fcs_mpc_pkg.sv
// Shared widths, FSM state encoding and arithmetic helpers for the FCS-MPC boost controller.
package fcs_mpc_pkg;

  localparam int unsigned W_DEF  = 8;
  localparam int unsigned KW_DEF = 8;
  localparam int unsigned PW     = W_DEF + KW_DEF + 2;
  localparam int unsigned CW     = W_DEF + 4;

  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t SAMPLE = 3'd1;
  localparam state_t PRED0  = 3'd2;
  localparam state_t PRED1  = 3'd3;
  localparam state_t DECIDE = 3'd4;

  function automatic logic [31:0] abs32(input logic signed [31:0] x);
    return (x < 0) ? 32'(-x) : 32'(x);
  endfunction

  function automatic logic [31:0] sat_cw(input logic [31:0] x, input int unsigned cw);
    logic [31:0] lim;
    lim = (32'd1 << cw) - 32'd1;
    return (x > lim) ? lim : x;
  endfunction

endpackage

// File: rtl/fcs_mpc_predict.sv
// One-step prediction of iL/vc for switch state s_i and the resulting saturated cost.
module fcs_mpc_predict
  import fcs_mpc_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned FRAC   = 6,
  parameter int unsigned K_L    = 16,
  parameter int unsigned K_C    = 8,
  parameter int unsigned LAMBDA = 32
) (
  input  logic          s_i,
  input  logic          mode_i,
  input  logic [W-1:0]  il_i,
  input  logic [W-1:0]  vc_i,
  input  logic [W-1:0]  vg_i,
  input  logic [W-1:0]  io_i,
  input  logic [W-1:0]  iref_i,
  input  logic [W-1:0]  vref_i,
  output logic [CW-1:0] cost_c
);

  logic signed [PW-1:0] il_s, vc_s, vg_s, io_s, iref_s, vref_s;
  logic signed [PW-1:0] kl_s, kc_s, dv, di, ilp, vcp;
  logic [31:0] gi, gv, sum;

  always_comb begin
    il_s   = signed'(PW'(il_i));
    vc_s   = signed'(PW'(vc_i));
    vg_s   = signed'(PW'(vg_i));
    io_s   = signed'(PW'(io_i));
    iref_s = signed'(PW'(iref_i));
    vref_s = signed'(PW'(vref_i));
    kl_s   = signed'(PW'(K_L));
    kc_s   = signed'(PW'(K_C));
    // S=1 shorts the inductor to ground and disconnects it from the capacitor
    dv  = s_i ? vg_s : vg_s - vc_s;
    di  = s_i ? -io_s : il_s - io_s;
    ilp = il_s + ((kl_s * dv) >>> FRAC);
    vcp = vc_s + ((kc_s * di) >>> FRAC);
    gi  = abs32(32'(iref_s - ilp));
    gv  = (32'(LAMBDA) * abs32(32'(vref_s - vcp))) >> FRAC;
    sum = gi + (mode_i ? gv : 32'd0);
    cost_c = CW'(sat_cw(sum, CW));
  end

endmodule

// File: rtl/fcs_mpc_core.sv
// FCS-MPC boost-converter controller: periodic sampling, two-state prediction,
// cost-based switch selection with minimum dwell and sticky overcurrent protection.
module fcs_mpc_core
  import fcs_mpc_pkg::*;
#(
  parameter int unsigned W          = W_DEF,
  parameter int unsigned KW         = KW_DEF,
  parameter int unsigned FRAC       = 6,
  parameter int unsigned K_L        = 16,
  parameter int unsigned K_C        = 8,
  parameter int unsigned LAMBDA     = 32,
  parameter int unsigned SAMPLE_DIV = 100,
  parameter int unsigned MIN_DWELL  = 1,
  parameter int unsigned I_MAX      = 240
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          en_i,
  input  logic          mode_i,
  input  logic [W-1:0]  iL_i,
  input  logic [W-1:0]  vc_i,
  input  logic [W-1:0]  vg_i,
  input  logic [W-1:0]  io_i,
  input  logic [W-1:0]  iref_i,
  input  logic [W-1:0]  vref_i,
  input  logic          fault_clr_i,
  output logic          u_o,
  output logic          io_oeb_o,
  output logic          u_valid_o,
  output logic          fault_o,
  output logic [CW-1:0] cost_o
);

  localparam int unsigned DIVW = $clog2(SAMPLE_DIV);
  localparam int unsigned DWW  = $clog2(MIN_DWELL + 1);

  if (SAMPLE_DIV < 6 || MIN_DWELL < 1 || W != W_DEF || KW != KW_DEF) begin : g_param_check
    $error("fcs_mpc_core: illegal parameter set");
  end

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DWW-1:0]  dwell_q, dwell_d;
  logic [W-1:0]    il_q, il_d, vc_q, vc_d, vg_q, vg_d, io_q, io_d;
  logic [W-1:0]    iref_q, iref_d, vref_q, vref_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   cost0_q, cost0_d, cost1_q, cost1_d, cost_q, cost_d;
  logic            u_q, u_d, oeb_q, oeb_d, valid_q, valid_d, fault_q, fault_d;
  logic            tick_c, trip_c, cand_c, u_new_c;
  logic [CW-1:0]   cost_pred_c;

  fcs_mpc_predict #(
    .W(W), .FRAC(FRAC), .K_L(K_L), .K_C(K_C), .LAMBDA(LAMBDA)
  ) u_predict (
    .s_i   (state_q == PRED1),
    .mode_i(mode_q),
    .il_i  (il_q),
    .vc_i  (vc_q),
    .vg_i  (vg_q),
    .io_i  (io_q),
    .iref_i(iref_q),
    .vref_i(vref_q),
    .cost_c(cost_pred_c)
  );

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    dwell_d = dwell_q;
    il_d = il_q; vc_d = vc_q; vg_d = vg_q; io_d = io_q;
    iref_d = iref_q; vref_d = vref_q; mode_d = mode_q;
    cost0_d = cost0_q; cost1_d = cost1_q; cost_d = cost_q;
    u_d = u_q; valid_d = 1'b0; oeb_d = ~en_i; fault_d = fault_q;

    tick_c = en_i && (div_q == DIVW'(SAMPLE_DIV - 1));
    trip_c = il_q > W'(I_MAX);
    if (cost1_q < cost0_q)      cand_c = 1'b1;
    else if (cost0_q < cost1_q) cand_c = 1'b0;
    else                        cand_c = u_q;
    u_new_c = (cand_c != u_q && dwell_q < DWW'(MIN_DWELL)) ? u_q : cand_c;
    if (trip_c || fault_q) u_new_c = 1'b0;

    if (en_i) div_d = tick_c ? '0 : div_q + DIVW'(1);
    if (fault_clr_i && iL_i <= W'(I_MAX)) fault_d = 1'b0;

    if (!en_i) begin
      state_d = IDLE;
      u_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE:   if (tick_c) state_d = SAMPLE;
        SAMPLE: begin
          il_d = iL_i; vc_d = vc_i; vg_d = vg_i; io_d = io_i;
          iref_d = iref_i; vref_d = vref_i; mode_d = mode_i;
          state_d = PRED0;
        end
        PRED0: begin
          cost0_d = cost_pred_c;
          state_d = PRED1;
        end
        PRED1: begin
          cost1_d = cost_pred_c;
          state_d = DECIDE;
        end
        DECIDE: begin
          u_d     = u_new_c;
          cost_d  = u_new_c ? cost1_q : cost0_q;
          valid_d = 1'b1;
          if (u_new_c != u_q)                dwell_d = DWW'(1);
          else if (dwell_q < DWW'(MIN_DWELL)) dwell_d = dwell_q + DWW'(1);
          // a trip in the deciding cycle overrides a concurrent clear
          if (trip_c) fault_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
      dwell_q <= DWW'(MIN_DWELL);
      il_q <= '0; vc_q <= '0; vg_q <= '0; io_q <= '0;
      iref_q <= '0; vref_q <= '0; mode_q <= 1'b0;
      cost0_q <= '0; cost1_q <= '0; cost_q <= '0;
      u_q <= 1'b0; oeb_q <= 1'b1; valid_q <= 1'b0; fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dwell_q <= dwell_d;
      il_q <= il_d; vc_q <= vc_d; vg_q <= vg_d; io_q <= io_d;
      iref_q <= iref_d; vref_q <= vref_d; mode_q <= mode_d;
      cost0_q <= cost0_d; cost1_q <= cost1_d; cost_q <= cost_d;
      u_q <= u_d; oeb_q <= oeb_d; valid_q <= valid_d; fault_q <= fault_d;
    end
  end

  assign u_o       = u_q;
  assign io_oeb_o  = oeb_q;
  assign u_valid_o = valid_q;
  assign fault_o   = fault_q;
  assign cost_o    = cost_q;

endmodule

// File: tb/tb_fcs_mpc_core.sv
// Directed self-checking bench for fcs_mpc_core (default build plus a MIN_DWELL=3 build).
module tb_fcs_mpc_core;

  localparam int unsigned SD = 100;

  logic clk = 1'b0;
  logic rst_n, en, mode, fclr;
  logic [7:0] il, vc, vg, io, iref, vref;
  logic u, oeb, valid, fault;
  logic [11:0] cost;
  logic u3, oeb3, valid3, fault3;
  logic [11:0] cost3;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fcs_mpc_core dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en), .mode_i(mode),
    .iL_i(il), .vc_i(vc), .vg_i(vg), .io_i(io), .iref_i(iref), .vref_i(vref),
    .fault_clr_i(fclr), .u_o(u), .io_oeb_o(oeb), .u_valid_o(valid),
    .fault_o(fault), .cost_o(cost)
  );

  fcs_mpc_core #(.MIN_DWELL(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en), .mode_i(mode),
    .iL_i(il), .vc_i(vc), .vg_i(vg), .io_i(io), .iref_i(iref), .vref_i(vref),
    .fault_clr_i(fclr), .u_o(u3), .io_oeb_o(oeb3), .u_valid_o(valid3),
    .fault_o(fault3), .cost_o(cost3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the selected decision pulse; a timeout shows up as a count mismatch.
  task automatic wait_valid(input bit sel3, input int exp_n, input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 2 * SD + 20) begin
      step();
      n++;
      seen = sel3 ? valid3 : valid;
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    bit leak;
    logic [7:0] dw_iref [7];
    logic       dw_u    [7];
    logic [11:0] dw_cost [7];
    dw_iref = '{8'd110, 8'd85, 8'd110, 8'd85, 8'd110, 8'd85, 8'd110};
    dw_u    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    dw_cost = '{12'd0, 12'd25, 12'd0, 12'd5, 12'd30, 12'd5, 12'd0};

    rst_n = 1'b0; en = 1'b1; mode = 1'b0; fclr = 1'b0;
    il = 8'd100; vg = 8'd40; vc = 8'd120; io = 8'd0; iref = 8'd110; vref = 8'd120;
    step();
    chk("rst_u", u, 0);
    chk("rst_oeb", oeb, 1);
    chk("rst_valid", valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cost", cost, 0);
    rst_n = 1'b1;

    // First decision: S1 cost 0, S0 cost 30
    wait_valid(1'b0, 104, "lat_first");
    chk("d1_u", u, 1);
    chk("d1_cost", cost, 0);
    chk("d1_oeb", oeb, 0);
    step();
    chk("d1_pulse_width", valid, 0);

    iref = 8'd85;
    wait_valid(1'b0, 99, "period_a");
    chk("d2_u", u, 0);
    chk("d2_cost", cost, 5);

    iref = 8'd95;
    wait_valid(1'b0, 100, "period_b");
    chk("tie_from0_u", u, 0);
    chk("tie_from0_cost", cost, 15);

    iref = 8'd110;
    wait_valid(1'b0, 100, "period_c");
    chk("d4_u", u, 1);
    chk("d4_cost", cost, 0);

    iref = 8'd95;
    wait_valid(1'b0, 100, "period_d");
    chk("tie_from1_u", u, 1);
    chk("tie_from1_cost", cost, 15);

    // Current-only vs weighted cost on the same operating point
    iref = 8'd94;
    wait_valid(1'b0, 100, "period_e");
    chk("mode0_u", u, 0);
    chk("mode0_cost", cost, 14);
    mode = 1'b1;
    wait_valid(1'b0, 100, "period_f");
    chk("mode1_u", u, 1);
    chk("mode1_cost", cost, 16);

    // Overcurrent trip forces S0 even though S1 wins on cost
    mode = 1'b0; il = 8'd245; iref = 8'd255;
    wait_valid(1'b0, 100, "period_g");
    chk("oc_u", u, 0);
    chk("oc_fault", fault, 1);
    chk("oc_cost", cost, 30);
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    chk("clr_blocked", fault, 1);

    il = 8'd100; iref = 8'd110;
    wait_valid(1'b0, 99, "period_h");
    chk("fault_forced_u", u, 0);
    chk("fault_sticky", fault, 1);
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    chk("clr_ok", fault, 0);
    wait_valid(1'b0, 99, "period_i");
    chk("resume_u", u, 1);
    chk("resume_cost", cost, 0);

    // Trip in the deciding cycle while clear is held with a safe live current
    il = 8'd245;
    repeat (97) step();
    il = 8'd100; fclr = 1'b1;
    repeat (3) step();
    chk("trip_vs_clr_valid", valid, 1);
    chk("trip_vs_clr_fault", fault, 1);
    chk("trip_vs_clr_u", u, 0);
    step();
    fclr = 1'b0;
    chk("clr_after_trip", fault, 0);
    wait_valid(1'b0, 99, "period_j");
    chk("pre_en_abort_u", u, 1);

    // Enable dropped while the FSM is in PRED0
    repeat (97) step();
    en = 1'b0;
    step();
    chk("en_abort_u", u, 0);
    chk("en_abort_valid", valid, 0);
    chk("en_abort_oeb", oeb, 1);
    leak = 1'b0;
    repeat (6) begin
      step();
      leak |= valid;
    end
    chk("en_abort_no_pulse", leak, 0);
    en = 1'b1; mode = 1'b1; iref = 8'd94;
    wait_valid(1'b0, 104, "en_restart");
    chk("en_restart_u", u, 1);
    chk("en_restart_cost", cost, 16);

    // Reset asserted while the FSM is in PRED1
    repeat (98) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_abort_u", u, 0);
    chk("rst_abort_cost", cost, 0);
    chk("rst_abort_valid", valid, 0);
    chk("rst_abort_oeb", oeb, 1);
    wait_valid(1'b0, 104, "rst_restart");
    chk("rst_restart_u", u, 1);

    // Minimum dwell of three decisions with alternating reference
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mode = 1'b0; iref = dw_iref[0];
    wait_valid(1'b1, 104, "dw_first");
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("dw_u_%0d", k), u3, dw_u[k]);
      chk($sformatf("dw_cost_%0d", k), cost3, dw_cost[k]);
      if (k < 6) begin
        iref = dw_iref[k + 1];
        wait_valid(1'b1, 100, $sformatf("dw_period_%0d", k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
